// File: rtl/icache_miss_ctrl.sv
// icache_miss_ctrl: miss/refill sequencer and tree-PLRU way-replacement owner
// for a 4-way pipelined instruction cache.
//
// Optional feature: define ICACHE_PERF_CNT_EN to add the saturating
// perf_miss / perf_wb event counters and their output ports.
//
// Ports:
//   clk, rst           clock, synchronous active-low reset
//   s2_*               stage-2 lookup result (hit/miss, set, hit way, addresses,
//                      dirty state of the current PLRU victim)
//   plru_way           combinational PLRU victim for s2_set
//   dfp_addr/read/write/resp  memory-side line request handshake
//   stall_sig          combinational front-end freeze
//   way_evict          way receiving the refill
//   dirty_flag         outstanding response belongs to a writeback
//   refill_done        one-cycle pulse: line installed, replay lookup
//   perf_miss, perf_wb (ICACHE_PERF_CNT_EN only) event counters
module icache_miss_ctrl #(
  parameter int unsigned NUM_SETS    = 16,
  parameter int unsigned LINE_OFFSET = 5
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        s2_hit,
  input  logic                        s2_miss,
  input  logic [$clog2(NUM_SETS)-1:0] s2_set,
  input  logic [1:0]                  s2_hit_way,
  input  logic [31:0]                 s2_addr,
  input  logic                        s2_victim_dirty,
  input  logic [31:0]                 s2_victim_addr,
  output logic [1:0]                  plru_way,
  output logic [31:0]                 dfp_addr,
  output logic                        dfp_read,
  output logic                        dfp_write,
  input  logic                        dfp_resp,
  output logic                        stall_sig,
  output logic [1:0]                  way_evict,
  output logic                        dirty_flag,
  output logic                        refill_done
`ifdef ICACHE_PERF_CNT_EN
  ,
  output logic [31:0]                 perf_miss,
  output logic [31:0]                 perf_wb
`endif
);

  localparam int unsigned SET_W  = $clog2(NUM_SETS);
  localparam int unsigned LINE_W = 32 - LINE_OFFSET;

  typedef enum logic [1:0] {IDLE, WB, ALLOC, DONE} state_t;

  state_t           state;
  logic [2:0]       plru [NUM_SETS];
  logic [SET_W-1:0] miss_set;
  logic [31:0]      miss_line;
  logic             miss_accept;

  // Byte-offset bits never reach the memory side.
  logic unused_offset_bits;
  assign unused_offset_bits = ^{s2_addr[LINE_OFFSET-1:0], s2_victim_addr[LINE_OFFSET-1:0]};

  // Tree PLRU bits {b2,b1,b0}: b0 picks the pair, b1/b2 the way inside it.
  function automatic logic [1:0] plru_victim(input logic [2:0] b);
    plru_victim = b[0] ? {1'b1, b[2]} : {1'b0, b[1]};
  endfunction

  function automatic logic [2:0] plru_touch(input logic [2:0] b, input logic [1:0] w);
    logic [2:0] r;
    r    = b;
    r[0] = ~w[1];
    if (w[1]) r[2] = ~w[0];
    else      r[1] = ~w[0];
    plru_touch = r;
  endfunction

  always_comb begin
    plru_way = plru_victim(plru[s2_set]);
  end

  assign stall_sig   = (state != IDLE) | s2_miss;
  assign miss_accept = (state == IDLE) & s2_miss;

  // Sequencer, PLRU storage and registered request outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      for (int i = 0; i < int'(NUM_SETS); i++) plru[i] <= 3'b000;
      miss_set    <= '0;
      miss_line   <= '0;
      dfp_addr    <= '0;
      dfp_read    <= 1'b0;
      dfp_write   <= 1'b0;
      dirty_flag  <= 1'b0;
      refill_done <= 1'b0;
      way_evict   <= 2'd0;
    end else begin
      refill_done <= 1'b0;
      case (state)
        IDLE: begin
          if (s2_miss) begin
            // A simultaneous hit is a protocol violation: handled as a miss only.
            way_evict <= plru_way;
            miss_set  <= s2_set;
            miss_line <= {s2_addr[31:LINE_OFFSET], LINE_OFFSET'(0)};
            if (s2_victim_dirty) begin
              state      <= WB;
              dfp_write  <= 1'b1;
              dirty_flag <= 1'b1;
              dfp_addr   <= {s2_victim_addr[31:LINE_OFFSET], LINE_OFFSET'(0)};
            end else begin
              state    <= ALLOC;
              dfp_read <= 1'b1;
              dfp_addr <= {s2_addr[31:LINE_OFFSET], LINE_OFFSET'(0)};
            end
          end else if (s2_hit) begin
            plru[s2_set] <= plru_touch(plru[s2_set], s2_hit_way);
          end
        end
        WB: begin
          if (dfp_resp) begin
            state      <= ALLOC;
            dfp_write  <= 1'b0;
            dirty_flag <= 1'b0;
            dfp_read   <= 1'b1;
            dfp_addr   <= miss_line;
          end
        end
        ALLOC: begin
          if (dfp_resp) begin
            state       <= DONE;
            dfp_read    <= 1'b0;
            refill_done <= 1'b1;
          end
        end
        DONE: begin
          plru[miss_set] <= plru_touch(plru[miss_set], way_evict);
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Line-width view kept for clarity of the address split.
  logic [LINE_W-1:0] unused_line_tag;
  assign unused_line_tag = miss_line[31:LINE_OFFSET];

`ifdef ICACHE_PERF_CNT_EN
  // Saturating event counters.
  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_miss <= '0;
      perf_wb   <= '0;
    end else if (miss_accept) begin
      if (perf_miss != 32'hFFFF_FFFF) perf_miss <= perf_miss + 32'd1;
      if (s2_victim_dirty && (perf_wb != 32'hFFFF_FFFF)) perf_wb <= perf_wb + 32'd1;
    end
  end
`else
  logic unused_accept;
  assign unused_accept = miss_accept;
`endif

endmodule

// File: tb/tb_icache_miss_ctrl.sv
// Self-checking bench for icache_miss_ctrl: directed scenarios followed by a
// randomized mix of hits, clean/dirty misses and stray responses, checked
// against a set-indexed PLRU model and a per-transaction protocol model.
module tb_icache_miss_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        s2_hit, s2_miss, s2_victim_dirty, dfp_resp;
  logic [3:0]  s2_set;
  logic [1:0]  s2_hit_way;
  logic [31:0] s2_addr, s2_victim_addr;
  logic [1:0]  plru_way, way_evict;
  logic [31:0] dfp_addr;
  logic        dfp_read, dfp_write, stall_sig, dirty_flag, refill_done;
`ifdef ICACHE_PERF_CNT_EN
  logic [31:0] perf_miss, perf_wb;
  int          exp_miss = 0, exp_wb = 0;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int mplru [16];

  always #5 clk = ~clk;

  icache_miss_ctrl dut (
    .clk(clk), .rst(rst),
    .s2_hit(s2_hit), .s2_miss(s2_miss), .s2_set(s2_set), .s2_hit_way(s2_hit_way),
    .s2_addr(s2_addr), .s2_victim_dirty(s2_victim_dirty), .s2_victim_addr(s2_victim_addr),
    .plru_way(plru_way), .dfp_addr(dfp_addr), .dfp_read(dfp_read), .dfp_write(dfp_write),
    .dfp_resp(dfp_resp), .stall_sig(stall_sig), .way_evict(way_evict),
    .dirty_flag(dirty_flag), .refill_done(refill_done)
`ifdef ICACHE_PERF_CNT_EN
    , .perf_miss(perf_miss), .perf_wb(perf_wb)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference PLRU: pair choice in bit 0, per-pair choice in bits 1 (ways 0/1) and 2 (ways 2/3).
  function automatic int ref_victim(input int b);
    if ((b % 2) == 1) return 2 + (b / 4) % 2;
    return (b / 2) % 2;
  endfunction

  function automatic int ref_touch(input int b, input int w);
    int lo_pair, b1, b2;
    lo_pair = (w < 2) ? 1 : 0;
    b1 = (b / 2) % 2;
    b2 = (b / 4) % 2;
    if (w < 2) b1 = (w == 0) ? 1 : 0;
    else       b2 = (w == 2) ? 1 : 0;
    return lo_pair + 2 * b1 + 4 * b2;
  endfunction

  task automatic check_bus(input string tag, input bit rd, input bit wr, input bit df,
                           input logic [31:0] addr, input int way);
    check({tag, ".dfp_read"},   32'(dfp_read),   32'(rd));
    check({tag, ".dfp_write"},  32'(dfp_write),  32'(wr));
    check({tag, ".dirty_flag"}, 32'(dirty_flag), 32'(df));
    check({tag, ".dfp_addr"},   dfp_addr,        addr);
    check({tag, ".way_evict"},  32'(way_evict),  32'(way));
    check({tag, ".stall_sig"},  32'(stall_sig),  32'd1);
  endtask

  task automatic idle_inputs();
    s2_hit = 1'b0; s2_miss = 1'b0; dfp_resp = 1'b0; s2_victim_dirty = 1'b0;
  endtask

  // Full miss transaction; busy-phase inputs carry junk that must be ignored.
  task automatic do_miss(input int set, input logic [31:0] addr, input bit dirty,
                         input logic [31:0] vaddr, input int wb_lat, input int rd_lat,
                         input bit with_hit, output int way);
    logic [31:0] mline, vline;
    mline = addr  & 32'hFFFF_FFE0;
    vline = vaddr & 32'hFFFF_FFE0;
    s2_miss = 1'b1; s2_hit = with_hit; s2_hit_way = 2'($urandom);
    s2_set = 4'(set); s2_addr = addr; s2_victim_dirty = dirty; s2_victim_addr = vaddr;
    #1;
    way = ref_victim(mplru[set]);
    check("miss.plru_way", 32'(plru_way), 32'(way));
    check("miss.stall_comb", 32'(stall_sig), 32'd1);
`ifdef ICACHE_PERF_CNT_EN
    exp_miss++;
    if (dirty) exp_wb++;
`endif
    tick();
    if (dirty) begin
      for (int k = 0; k <= wb_lat; k++) begin
        s2_miss = 1'($urandom); s2_hit = 1'($urandom); s2_set = 4'($urandom);
        s2_victim_dirty = 1'($urandom);
        dfp_resp = (k == wb_lat);
        check_bus("wb", 1'b0, 1'b1, 1'b1, vline, way);
        tick();
      end
    end
    for (int k = 0; k <= rd_lat; k++) begin
      s2_miss = 1'($urandom); s2_hit = 1'($urandom); s2_set = 4'($urandom);
      dfp_resp = (k == rd_lat);
      check_bus("alloc", 1'b1, 1'b0, 1'b0, mline, way);
      check("alloc.refill_done", 32'(refill_done), 32'd0);
      tick();
    end
    dfp_resp = 1'($urandom);
    check_bus("done", 1'b0, 1'b0, 1'b0, mline, way);
    check("done.refill_done", 32'(refill_done), 32'd1);
    tick();
    idle_inputs();
    mplru[set] = ref_touch(mplru[set], way);
    s2_set = 4'(set);
    #1;
    check("idle.refill_done", 32'(refill_done), 32'd0);
    check("idle.stall_sig", 32'(stall_sig), 32'd0);
    check("idle.dfp_read", 32'(dfp_read), 32'd0);
    check("idle.plru_way", 32'(plru_way), 32'(ref_victim(mplru[set])));
  endtask

  task automatic do_hit(input int set, input int way, input bit stray);
    s2_hit = 1'b1; s2_hit_way = 2'(way); s2_set = 4'(set); dfp_resp = stray;
    #1;
    check("hit.stall_sig", 32'(stall_sig), 32'd0);
    tick();
    idle_inputs();
    mplru[set] = ref_touch(mplru[set], way);
    #1;
    check("hit.plru_way", 32'(plru_way), 32'(ref_victim(mplru[set])));
    check("hit.dfp_read", 32'(dfp_read | dfp_write | refill_done), 32'd0);
  endtask

  int way;
  int order [4];

  initial begin
    rst = 1'b0; idle_inputs();
    s2_set = '0; s2_hit_way = '0; s2_addr = '0; s2_victim_addr = '0;
    foreach (mplru[i]) mplru[i] = 0;
    tick(); tick();
    check("reset.dfp_read", 32'(dfp_read), 32'd0);
    check("reset.dfp_write", 32'(dfp_write), 32'd0);
    check("reset.dirty_flag", 32'(dirty_flag), 32'd0);
    check("reset.refill_done", 32'(refill_done), 32'd0);
    check("reset.way_evict", 32'(way_evict), 32'd0);
    check("reset.dfp_addr", dfp_addr, 32'd0);
    rst = 1'b1;
    tick();

    // Scramble PLRU, then reset in the middle of ALLOC.
    do_hit(1, 0, 1'b0);
    do_hit(9, 3, 1'b0);
    s2_miss = 1'b1; s2_set = 4'd2; s2_addr = 32'h0000_4444; s2_victim_dirty = 1'b0;
    tick();
    s2_miss = 1'b0;
    tick();
    check("pre_reset.dfp_read", 32'(dfp_read), 32'd1);
    rst = 1'b0;
    tick(); tick();
    rst = 1'b1;
    foreach (mplru[i]) mplru[i] = 0;
    #1;
    check("rst_alloc.dfp_read", 32'(dfp_read), 32'd0);
    check("rst_alloc.stall_sig", 32'(stall_sig), 32'd0);
    for (int s = 0; s < 16; s++) begin
      s2_set = 4'(s);
      #1;
      check("rst_alloc.plru_way", 32'(plru_way), 32'd0);
    end
    dfp_resp = 1'b1;
    tick();
    dfp_resp = 1'b0;
    #1;
    check("late_resp.dfp_read", 32'(dfp_read), 32'd0);
    check("late_resp.refill_done", 32'(refill_done), 32'd0);
    check("late_resp.stall_sig", 32'(stall_sig), 32'd0);

    // Clean miss then dirty miss in set 3.
    do_miss(3, 32'h0000_1064, 1'b0, 32'h0, 0, 5, 1'b0, way);
    check("clean.way", 32'(way), 32'd0);
    s2_set = 4'd3; #1;
    check("clean.set3_plru_way", 32'(plru_way), 32'd2);
    do_miss(3, 32'h0000_3064, 1'b1, 32'h0000_2060, 3, 2, 1'b0, way);
`ifdef ICACHE_PERF_CNT_EN
    check("perf.miss_after_2", perf_miss, 32'd2);
    check("perf.wb_after_2", perf_wb, 32'd1);
`endif

    // Four misses to a fresh set walk every way.
    for (int i = 0; i < 4; i++) do_miss(5, 32'h0001_00A0 + 32'(i) * 32'h1000, 1'b0, 32'h0, 1, 1, 1'b0, order[i]);
    check("order.0", 32'(order[0]), 32'd0);
    check("order.1", 32'(order[1]), 32'd2);
    check("order.2", 32'(order[2]), 32'd1);
    check("order.3", 32'(order[3]), 32'd3);

    // Hit way 2 in a fresh set, then a stray response in IDLE.
    do_hit(7, 2, 1'b1);
    check("hit7.plru_way", 32'(plru_way), 32'd0);

    // Simultaneous hit+miss behaves as a plain miss.
    do_miss(11, 32'h0000_8B20, 1'b0, 32'h0, 0, 0, 1'b1, way);

    // Randomized traffic.
    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 2) == 0)
        do_miss($urandom_range(0, 15), $urandom, 1'($urandom), $urandom,
                $urandom_range(0, 4), $urandom_range(0, 4), 1'($urandom_range(0, 5) == 0), way);
      else
        do_hit($urandom_range(0, 15), $urandom_range(0, 3), 1'($urandom));
    end
`ifdef ICACHE_PERF_CNT_EN
    check("perf.miss_total", perf_miss, 32'(exp_miss));
    check("perf.wb_total", perf_wb, 32'(exp_wb));
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
